// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: branch bit indices,
// ALU op class encodings and the control word with its bubble value.
// Optional feature macro: ID_EX_PERF_CNT_EN (see id_ex_stage.sv).
package id_ex_stage_pkg;

    // Bit positions inside the 2-bit branch field
    localparam int BRANCH_BEQ = 0;
    localparam int BRANCH_BNE = 1;

    // ALU op class encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Control word carried from ID into EX
    typedef struct packed {
        logic [1:0] branch;
        logic [1:0] aluop;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrc;
        logic       valid;
    } ctrl_t;

    // A bubble does nothing: every control deasserted and not valid
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a valid load in EX whose destination (rt) is
// read by the valid instruction in ID. Register 0 never conflicts.
module hazard_detect #(
    parameter int REGBITS = 5
) (
    input  logic               memread_x,
    input  logic               valid_x,
    input  logic [REGBITS-1:0] rt_x,
    input  logic [REGBITS-1:0] rs_d,
    input  logic [REGBITS-1:0] rt_d,
    input  logic               rt_used_d,
    input  logic               valid_d,
    output logic               hazard
);

    logic load_in_ex;
    logic reg_match;

    // Combine the load-in-EX condition with a source-register match
    always_comb begin
        load_in_ex = memread_x && valid_x && valid_d && (rt_x != '0);
        reg_match  = (rt_x == rs_d) || ((rt_x == rt_d) && rt_used_d);
        hazard     = load_in_ex && reg_match;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush
// and downstream hold. Define ID_EX_PERF_CNT_EN to add bubble/hold counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         branch_d,
    input  logic [1:0]         aluop_d,
    input  logic               memread_d,
    input  logic               memwrite_d,
    input  logic               memtoreg_d,
    input  logic               regdst_d,
    input  logic               regwrite_d,
    input  logic               alusrc_d,
    input  logic               valid_d,
    input  logic [WIDTH-1:0]   pc4_d,
    input  logic [WIDTH-1:0]   rd1_d,
    input  logic [WIDTH-1:0]   rd2_d,
    input  logic [WIDTH-1:0]   imm_d,
    input  logic [REGBITS-1:0] rs_d,
    input  logic [REGBITS-1:0] rt_d,
    input  logic [REGBITS-1:0] rd_d,
    input  logic               flush,
    input  logic               hold,
    output logic               stall,
    output logic [1:0]         branch_x,
    output logic [1:0]         aluop_x,
    output logic               memread_x,
    output logic               memwrite_x,
    output logic               memtoreg_x,
    output logic               regdst_x,
    output logic               regwrite_x,
    output logic               alusrc_x,
    output logic               valid_x,
    output logic [WIDTH-1:0]   pc4_x,
    output logic [WIDTH-1:0]   rd1_x,
    output logic [WIDTH-1:0]   rd2_x,
    output logic [WIDTH-1:0]   imm_x,
    output logic [REGBITS-1:0] rs_x,
    output logic [REGBITS-1:0] rt_x,
    output logic [REGBITS-1:0] rd_x
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]        bubble_cnt,
    output logic [31:0]        hold_cnt
`endif
);

    ctrl_t              ctrl_q;
    ctrl_t              ctrl_in;
    logic [WIDTH-1:0]   pc4_q, rd1_q, rd2_q, imm_q;
    logic [REGBITS-1:0] rs_q, rt_q, rd_q;
    logic               rt_used_d;
    logic               hazard;

    // Gather the decoder controls into one word; lw/addi write rt rather than read it
    always_comb begin
        ctrl_in   = '{branch: branch_d, aluop: aluop_d, memread: memread_d,
                      memwrite: memwrite_d, memtoreg: memtoreg_d, regdst: regdst_d,
                      regwrite: regwrite_d, alusrc: alusrc_d, valid: valid_d};
        rt_used_d = !(alusrc_d && !memwrite_d);
    end

    hazard_detect #(.REGBITS(REGBITS)) u_hazard (
        .memread_x (ctrl_q.memread),
        .valid_x   (ctrl_q.valid),
        .rt_x      (rt_q),
        .rs_d      (rs_d),
        .rt_d      (rt_d),
        .rt_used_d (rt_used_d),
        .valid_d   (valid_d),
        .hazard    (hazard)
    );

    // Freeze the front end on a hazard or hold unless a flush squashes ID anyway
    always_comb begin
        stall = (hazard || hold) && !flush;
    end

    // Pipeline register update: flush > hold > hazard bubble > normal advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= CTRL_BUBBLE;
            pc4_q  <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else if (!hold || flush) begin
            ctrl_q <= (flush || hazard) ? CTRL_BUBBLE : ctrl_in;
            pc4_q  <= pc4_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            rd_q   <= rd_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Count hazard bubbles (not flush bubbles) and held edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else begin
            if (hazard && !hold && !flush) bubble_cnt <= bubble_cnt + 32'd1;
            if (hold && !flush)            hold_cnt   <= hold_cnt + 32'd1;
        end
    end
`endif

    // Drive the registered fields onto the EX-side ports
    always_comb begin
        branch_x   = ctrl_q.branch;
        aluop_x    = ctrl_q.aluop;
        memread_x  = ctrl_q.memread;
        memwrite_x = ctrl_q.memwrite;
        memtoreg_x = ctrl_q.memtoreg;
        regdst_x   = ctrl_q.regdst;
        regwrite_x = ctrl_q.regwrite;
        alusrc_x   = ctrl_q.alusrc;
        valid_x    = ctrl_q.valid;
        pc4_x      = pc4_q;
        rd1_x      = rd1_q;
        rd2_x      = rd2_q;
        imm_x      = imm_q;
        rs_x       = rs_q;
        rt_x       = rt_q;
        rd_x       = rd_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed load-use/flush/hold/reset
// scenarios followed by random traffic, against an instruction-level model.
module tb_id_ex_stage;

    typedef struct {
        bit [1:0]  br;
        bit [1:0]  aluop;
        bit        mr, mw, mtr, rdst, rw, as, v;
        bit [31:0] pc4, rd1, rd2, imm;
        bit [4:0]  rs, rt, rd;
    } instr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush_v = 1'b0;
    logic hold_v = 1'b0;
    instr_t id;
    instr_t ex;
    bit data_known;
    int unsigned exp_bubbles;
    int unsigned exp_holds;
    int total = 0;
    int bad = 0;

    logic [1:0]  branch_x, aluop_x;
    logic        memread_x, memwrite_x, memtoreg_x, regdst_x, regwrite_x, alusrc_x, valid_x;
    logic [31:0] pc4_x, rd1_x, rd2_x, imm_x;
    logic [4:0]  rs_x, rt_x, rd_x;
    logic        stall;
    logic [1:0]  branch_d, aluop_d;
    logic        memread_d, memwrite_d, memtoreg_d, regdst_d, regwrite_d, alusrc_d, valid_d;
    logic [31:0] pc4_d, rd1_d, rd2_d, imm_d;
    logic [4:0]  rs_d, rt_d, rd_d;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, hold_cnt;
`endif

    always #5 clk = ~clk;

    assign branch_d = id.br;   assign aluop_d = id.aluop;
    assign memread_d = id.mr;  assign memwrite_d = id.mw;
    assign memtoreg_d = id.mtr; assign regdst_d = id.rdst;
    assign regwrite_d = id.rw; assign alusrc_d = id.as;
    assign valid_d = id.v;     assign pc4_d = id.pc4;
    assign rd1_d = id.rd1;     assign rd2_d = id.rd2;
    assign imm_d = id.imm;     assign rs_d = id.rs;
    assign rt_d = id.rt;       assign rd_d = id.rd;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .branch_d(branch_d), .aluop_d(aluop_d),
        .memread_d(memread_d), .memwrite_d(memwrite_d), .memtoreg_d(memtoreg_d),
        .regdst_d(regdst_d), .regwrite_d(regwrite_d), .alusrc_d(alusrc_d),
        .valid_d(valid_d), .pc4_d(pc4_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .flush(flush_v), .hold(hold_v), .stall(stall),
        .branch_x(branch_x), .aluop_x(aluop_x),
        .memread_x(memread_x), .memwrite_x(memwrite_x), .memtoreg_x(memtoreg_x),
        .regdst_x(regdst_x), .regwrite_x(regwrite_x), .alusrc_x(alusrc_x),
        .valid_x(valid_x), .pc4_x(pc4_x), .rd1_x(rd1_x), .rd2_x(rd2_x), .imm_x(imm_x),
        .rs_x(rs_x), .rt_x(rt_x), .rd_x(rd_x)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic instr_t nop();
        instr_t n;
        n = '{default: '0};
        return n;
    endfunction

    // A bubble keeps the data (don't-care) but drops every control and valid
    function automatic instr_t as_bubble(input instr_t x);
        instr_t b;
        b = x;
        b.br = 0; b.aluop = 0; b.mr = 0; b.mw = 0; b.mtr = 0;
        b.rdst = 0; b.rw = 0; b.as = 0; b.v = 0;
        return b;
    endfunction

    // Load-use rule: a valid load in EX whose nonzero rt is read by ID
    function automatic bit model_hazard();
        bit rt_is_source;
        rt_is_source = !(id.as && !id.mw);
        return ex.mr && ex.v && id.v && (ex.rt != 0) &&
               ((ex.rt == id.rs) || (ex.rt == id.rt && rt_is_source));
    endfunction

    task automatic check_outputs();
        chk("ctrl", {23'd0, branch_x, aluop_x, memread_x, memwrite_x, memtoreg_x,
                     regdst_x, regwrite_x, alusrc_x, valid_x},
                    {23'd0, ex.br, ex.aluop, ex.mr, ex.mw, ex.mtr, ex.rdst, ex.rw, ex.as, ex.v});
        if (data_known) begin
            chk("pc4", pc4_x, ex.pc4);
            chk("rd1", rd1_x, ex.rd1);
            chk("rd2", rd2_x, ex.rd2);
            chk("imm", imm_x, ex.imm);
            chk("regs", {17'd0, rs_x, rt_x, rd_x}, {17'd0, ex.rs, ex.rt, ex.rd});
        end
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt", bubble_cnt, exp_bubbles);
        chk("hold_cnt", hold_cnt, exp_holds);
`endif
    endtask

    // One clock: check stall mid-cycle, advance the model, check EX outputs
    task automatic step(input string tag);
        bit hz;
        hz = model_hazard();
        @(negedge clk);
        chk({tag, ":stall"}, {31'd0, stall}, {31'd0, (hz || hold_v) && !flush_v});
        @(posedge clk);
        if (hold_v && !flush_v) exp_holds++;
        if (flush_v) begin
            ex = as_bubble(id); data_known = 0;
        end else if (hold_v) begin
            // frozen
        end else if (hz) begin
            ex = as_bubble(id); data_known = 0; exp_bubbles++;
        end else begin
            ex = id; data_known = 1;
        end
        #1;
        check_outputs();
        $display("step %s: valid_x=%0b memread_x=%0b rs_x=%0d rt_x=%0d stall_next=%0b",
                 tag, valid_x, memread_x, rs_x, rt_x, stall);
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear at once
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        hold_v = 0; flush_v = 0;
        #1;
        ex = nop(); data_known = 1; exp_bubbles = 0; exp_holds = 0;
        check_outputs();
        chk({tag, ":stall"}, {31'd0, stall}, 32'd0);
        $display("reset %s: valid_x=%0b stall=%0b", tag, valid_x, stall);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic instr_t lw(input bit [4:0] base, input bit [4:0] dst);
        instr_t i;
        i = nop();
        i.mr = 1; i.rw = 1; i.as = 1; i.mtr = 1; i.v = 1;
        i.rs = base; i.rt = dst; i.imm = 32'h10; i.pc4 = 32'h100; i.rd1 = 32'h2000;
        return i;
    endfunction

    function automatic instr_t rtype(input bit [4:0] s, input bit [4:0] t, input bit [4:0] d);
        instr_t i;
        i = nop();
        i.rw = 1; i.rdst = 1; i.aluop = 2'b10; i.v = 1;
        i.rs = s; i.rt = t; i.rd = d; i.pc4 = 32'h104; i.rd1 = 32'h11; i.rd2 = 32'h22;
        return i;
    endfunction

    initial begin
        id = nop(); ex = nop(); data_known = 1; exp_bubbles = 0; exp_holds = 0;
        @(posedge clk); #1;
        do_reset("init");

        // Load-use: lw $8 ; add $9,$8,$1 -> one bubble then the add
        id = lw(5'd2, 5'd8);        step("lw8");
        id = rtype(5'd8, 5'd1, 5'd9); step("add_stall");
        chk("bubble_valid", {31'd0, valid_x}, 32'd0);
        step("add_enter");
        chk("add_rs", {27'd0, rs_x}, 32'd8);

        // addi $8,$8 style: rt matches but is a destination, rs differs
        id = lw(5'd2, 5'd8);        step("lw8b");
        id = rtype(5'd3, 5'd8, 5'd0); id.as = 1; id.rdst = 0; step("addi_nohaz");
        // lw $0 then add reading $0
        id = lw(5'd2, 5'd0);        step("lw0");
        id = rtype(5'd0, 5'd0, 5'd4); step("add_r0");

        // sw $5 after lw $5: store data is an rt source
        id = lw(5'd2, 5'd5);        step("lw5");
        id = nop(); id.mw = 1; id.as = 1; id.v = 1; id.rs = 5'd2; id.rt = 5'd5;
        step("sw_stall");
        step("sw_enter");

        // Flush together with a hazard: flush wins, no stall
        id = lw(5'd2, 5'd7);        step("lw7");
        id = rtype(5'd7, 5'd1, 5'd3); flush_v = 1; step("flush_haz");
        flush_v = 0;

        // Hold for 3 cycles with a pending hazard, then exactly one bubble
        do_reset("pre_hold");
        id = lw(5'd2, 5'd8);        step("lw8h");
        id = rtype(5'd8, 5'd1, 5'd9); hold_v = 1;
        step("hold1"); step("hold2"); step("hold3");
        hold_v = 0;
        step("hold_bubble");
        step("hold_add");
`ifdef ID_EX_PERF_CNT_EN
        chk("hold_cnt_3", hold_cnt, 32'd3);
        chk("bubble_cnt_1", bubble_cnt, 32'd1);
`endif

        // Reset in the middle of a hold discards everything
        id = lw(5'd2, 5'd6);        step("lw6");
        id = rtype(5'd6, 5'd6, 5'd1); hold_v = 1; step("hold_pre_rst");
        do_reset("mid_hold");

        // Random traffic on a small register set so conflicts are common
        for (int n = 0; n < 300; n++) begin
            id.br = 2'($urandom); id.aluop = 2'($urandom_range(0, 2));
            id.mr = ($urandom_range(0, 2) == 0); id.mw = ($urandom_range(0, 4) == 0);
            id.mtr = id.mr; id.rdst = 1'($urandom); id.rw = 1'($urandom);
            id.as = 1'($urandom); id.v = ($urandom_range(0, 5) != 0);
            id.pc4 = $urandom; id.rd1 = $urandom; id.rd2 = $urandom; id.imm = $urandom;
            id.rs = 5'($urandom_range(0, 3)); id.rt = 5'($urandom_range(0, 3));
            id.rd = 5'($urandom);
            flush_v = ($urandom_range(0, 9) == 0);
            hold_v  = ($urandom_range(0, 6) == 0);
            step("rand");
        end
        flush_v = 0; hold_v = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the opcode decoder.
- Latches the decoder's control word, plus register-file operands, the sign-extended immediate, PC+4 and register specifiers, for the EX stage.
- Contains load-use hazard detection: it inserts a bubble into EX and stalls PC/IF-ID for one cycle.
- Honours a branch flush and a downstream hold.

Parameters:
- WIDTH, 32, datapath width (operands, immediate, PC+4).
- REGBITS, 5, register specifier width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- branch_d  in  2  decoded branch; bit0 = beq, bit1 = bne.
- aluop_d  in  2  decoded ALU op class.
- memread_d, memwrite_d, memtoreg_d, regdst_d, regwrite_d, alusrc_d  in  1 each  decoded controls.
- valid_d  in  1  ID holds a real instruction.
- pc4_d, rd1_d, rd2_d, imm_d  in  WIDTH each  PC+4, rs data, rt data, sign-extended immediate.
- rs_d, rt_d, rd_d  in  REGBITS each  register specifiers.
- flush  in  1  branch taken, resolved downstream; squash ID.
- hold  in  1  downstream not ready; freeze ID/EX.
- stall  out  1  freeze PC and IF/ID this cycle.
- branch_x, aluop_x  out  2 each  registered controls.
- memread_x, memwrite_x, memtoreg_x, regdst_x, regwrite_x, alusrc_x  out  1 each  registered controls.
- valid_x  out  1  EX holds a real instruction.
- pc4_x, rd1_x, rd2_x, imm_x  out  WIDTH each  registered data.
- rs_x, rt_x, rd_x  out  REGBITS each  registered specifiers.

Behaviour:
- Reset:
  - Every registered output is 0.
  - The bubble control word is all controls 0 and valid_x 0. It is reached immediately on reset assertion, independent of clk.
  - Reset mid-stall or mid-hold discards all state.
- rt_used_d = !(alusrc_d && !memwrite_d). lw and addi write rt, so their rt is not a source.
- Hazard condition (combinational), all four must hold:
  - memread_x && valid_x && valid_d;
  - rt_x != 0;
  - (rt_x == rs_d) || (rt_x == rt_d && rt_used_d);
  - register 0 never causes a hazard (covered by rt_x != 0).
- stall = (hazard || hold) && !flush.
  - stall is combinational from the registered EX fields plus ID inputs.
  - stall never depends on itself.
- Update priority at each rising clk edge:
  1. flush: load the bubble. Data fields load the ID inputs (their values are don't-care).
  2. hold: all outputs keep their value.
  3. hazard: load the bubble. Data fields load the ID inputs.
  4. Otherwise: load every output from its _d input; valid_x = valid_d.
- Latency is 1 cycle from ID inputs to _x outputs.
- A load-use pair costs exactly 1 bubble. After the bubble, memread_x = 0, so the hazard clears by construction.
- hold with a pending hazard:
  - ID/EX is frozen; stall stays high for the whole hold.
  - After hold drops, the hazard is re-evaluated and one bubble is inserted if it still applies.
- flush together with hazard or hold: flush wins. The bubble is loaded and stall = 0 that cycle.
- When valid_d = 0, the _d controls are still latched as presented. The decoder is responsible for driving benign values.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs bubble_cnt [31:0] and hold_cnt [31:0].
  - bubble_cnt increments on every hazard-bubble edge; flush bubbles are not counted.
  - hold_cnt increments on every edge with hold = 1 and flush = 0.
  - Both counters wrap modulo 2^32 and reset to 0.
- Not defined: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - BRANCH_BEQ = 0 and BRANCH_BNE = 1 bit indices;
  - the ALUOP encodings (00 add, 01 sub, 10 funct);
  - the bubble control-word constant.
- One natural sub-module: hazard_detect, pure combinational. It takes memread_x, valid_x, rt_x, rs_d, rt_d, rt_used_d and valid_d, and produces hazard.

Test Plan:
1. Reset: assert reset mid-cycle with stale data -> all outputs 0 immediately; stall = 0.
2. Load-use: lw $8 then add $9,$8,$1 -> 1 cycle with stall = 1; one bubble (valid_x = 0, regwrite_x = 0) in EX; the add enters EX next cycle with rs_x = 8.
3. No false hazard: lw $8 then addi $8,$8... variant with rt_d = 8 and alusrc_d = 1 -> no stall when rs_d != 8. lw $0 then add with rs = 0 -> no stall.
4. sw after lw: lw $5 then sw $5,0($2) (rt_used_d = 1) -> stall = 1, one bubble.
5. Flush vs hazard: hazard and flush in the same cycle -> stall = 0, bubble loaded, valid_x = 0.
6. Hold: hold = 1 for 3 cycles with a hazard pending -> outputs frozen, stall high all 3 cycles; after release, exactly one bubble. With ID_EX_PERF_CNT_EN: hold_cnt = 3, bubble_cnt = 1.
